// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: debounced pushbutton select controller driving a registered 2:1 LED mux.
// Define AUTO_TOGGLE_EN to build the long-press AUTO mode (periodic select toggling).
module mux_sel_ctrl #(
    parameter int W            = 4,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int HOLD_CYC     = 50000000,
    parameter int AUTO_PERIOD  = 25000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pba,
    input  logic [W-1:0] ina,
    input  logic [W-1:0] inb,
    output logic [W-1:0] led,
    output logic         sel,
    output logic         press_pulse,
    output logic         auto_mode
);
    localparam int MAXC = (DEBOUNCE_CYC > HOLD_CYC)
                          ? ((DEBOUNCE_CYC > AUTO_PERIOD) ? DEBOUNCE_CYC : AUTO_PERIOD)
                          : ((HOLD_CYC > AUTO_PERIOD) ? HOLD_CYC : AUTO_PERIOD);
    localparam int CW = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

`ifdef AUTO_TOGGLE_EN
    typedef enum logic [1:0] {MAN_A, MAN_B, AUTO} state_t;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] PER_LAST  = CW'(AUTO_PERIOD - 1);
    logic [CW-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d;
    logic          hold_q, hold_d;
`else
    typedef enum logic {MAN_A, MAN_B} state_t;
`endif

    state_t        state_q, state_d;
    logic          s1_q, s2_q, stable_q, stable_d, stdly_q, arm_q, arm_d, sel_q, sel_d;
    logic          pulse_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  led_q;
    logic          press;

    assign press       = stdly_q & ~stable_q;
    assign led         = led_q;
    assign sel         = sel_q;
    assign press_pulse = pulse_q;
`ifdef AUTO_TOGGLE_EN
    assign auto_mode = (state_q == AUTO);
`else
    assign auto_mode = 1'b0;
`endif

    // Debounce; until a debounced release is seen after reset (arm_q), a held button is ignored
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        arm_d    = arm_q;
        if (!arm_q) begin
            if (s1_q & s2_q) begin
                if (cnt_q == DB_LAST) arm_d = 1'b1;
                else cnt_d = cnt_q + 1'b1;
            end
        end else if (s2_q != stable_q) begin
            if (cnt_q == DB_LAST) stable_d = s2_q;
            else cnt_d = cnt_q + 1'b1;
        end
    end

    // Select FSM: a press toggles between manual states, a long press enters AUTO
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
`ifdef AUTO_TOGGLE_EN
        hold_d  = hold_q & ~stable_q;
        hcnt_d  = '0;
        pcnt_d  = '0;
        if (state_q == AUTO) begin
            if (press) state_d = sel_q ? MAN_B : MAN_A;
            else if (pcnt_q == PER_LAST) sel_d = ~sel_q;
            else pcnt_d = pcnt_q + 1'b1;
        end else if (press) begin
            state_d = sel_q ? MAN_A : MAN_B;
            sel_d   = ~sel_q;
            hold_d  = 1'b1;
        end else if (hold_q & ~stable_q) begin
            if (hcnt_q == HOLD_LAST) begin
                state_d = AUTO;
                hold_d  = 1'b0;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
`else
        if (press) begin
            state_d = sel_q ? MAN_A : MAN_B;
            sel_d   = ~sel_q;
        end
`endif
    end

    // State, synchroniser, debounce and registered mux output
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            stable_q <= 1'b1;
            stdly_q  <= 1'b1;
            arm_q    <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            sel_q    <= 1'b0;
            led_q    <= '0;
            state_q  <= MAN_A;
`ifdef AUTO_TOGGLE_EN
            hcnt_q   <= '0;
            pcnt_q   <= '0;
            hold_q   <= 1'b0;
`endif
        end else begin
            s1_q     <= pba;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            stdly_q  <= stable_q;
            arm_q    <= arm_d;
            cnt_q    <= cnt_d;
            pulse_q  <= press;
            sel_q    <= sel_d;
            led_q    <= sel_q ? inb : ina;
            state_q  <= state_d;
`ifdef AUTO_TOGGLE_EN
            hcnt_q   <= hcnt_d;
            pcnt_q   <= pcnt_d;
            hold_q   <= hold_d;
`endif
        end
    end
endmodule
